// File: rtl/product_bcd_display_if.sv
// product_bcd_display_if: operand handshake and display result bundle for the BCD display stage
interface product_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_Valid;
    logic                  o_Ready;
    logic [WIDTH-1:0]      i_Bin;
    logic                  i_Overflow;
    logic [4*DIGITS-1:0]   o_Bcd;
    logic [7*DIGITS-1:0]   o_Seg;
    logic                  o_Overflow;
    logic                  o_Done;
    modport master (
        output i_Valid, i_Bin, i_Overflow,
        input  o_Ready, o_Bcd, o_Seg, o_Overflow, o_Done
    );
    modport slave (
        input  i_Valid, i_Bin, i_Overflow,
        output o_Ready, o_Bcd, o_Seg, o_Overflow, o_Done
    );
endinterface

// File: rtl/product_bcd_display.sv
// product_bcd_display: serial double-dabble binary-to-BCD converter driving held active-low seven-segment digits
module product_bcd_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    product_bcd_display_if.slave   bus
);
    localparam int SW = 4 * DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7*DIGITS-1:0] SEG_RST = (BLANK_LZ != 0)
        ? {{(7*(DIGITS-1)){1'b1}}, SEG_ZERO}
        : {DIGITS{SEG_ZERO}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          sr_q, sr_d, adj;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   cap_q, cap_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [7*DIGITS-1:0]    seg_q, seg_d, seg_nxt;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic [3:0]             dig;
    logic                   lz;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // add-3 correction of every BCD digit >= 5 ahead of the next shift
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < DIGITS; i++)
            adj[WIDTH+4*i +: 4] = (sr_q[WIDTH+4*i +: 4] >= 4'd5) ? sr_q[WIDTH+4*i +: 4] + 4'd3 : sr_q[WIDTH+4*i +: 4];
    end

    // segment decode of the finished BCD field with leading-zero blanking from the top digit down
    always_comb begin
        seg_nxt = '1;
        dig     = '0;
        lz      = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = sr_q[WIDTH+4*i +: 4];
            lz  = lz && (dig == 4'd0);
            seg_nxt[7*i +: 7] = (BLANK_LZ != 0 && lz && i != 0) ? SEG_BLANK : seg7(dig);
        end
    end

    // next-state and datapath: accept in IDLE, shift WIDTH times, publish results in DONE
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.i_Valid) begin
                sr_d    = {{(4*DIGITS){1'b0}}, bus.i_Bin};
                cap_d   = bus.i_Overflow;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d    = adj << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_LAST) ? DONE : SHIFT;
            end
            DONE: begin
                bcd_d   = sr_q[SW-1 -: 4*DIGITS];
                seg_d   = seg_nxt;
                ovf_d   = cap_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // state and output registers; reset discards any conversion in flight
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            bcd_q   <= '0;
            seg_q   <= SEG_RST;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_Ready    = ready_q;
    assign bus.o_Bcd      = bcd_q;
    assign bus.o_Seg      = seg_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Done     = done_q;
endmodule

// File: tb/tb_product_bcd_display.sv
// tb_product_bcd_display: randomized scoreboard bench for the BCD display stage
module tb_product_bcd_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    product_bcd_display_if #(.WIDTH(8), .DIGITS(3)) bus ();
    product_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus)
    );

    typedef struct { int v; bit o; int acc; } exp_t;
    localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] BLK = 7'h7F;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk = 0, n_fail = 0, cyc = 0;
    bit   inflight = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [20:0] model_seg(input int v);
        return {v >= 100 ? PAT[v / 100] : BLK, v >= 10 ? PAT[(v / 10) % 10] : BLK, PAT[v % 10]};
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (bus.o_Done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(bus.o_Done), 32'd0);
            else begin
                m_e = sb.pop_front();
                chk("bcd", 32'(bus.o_Bcd), 32'(model_bcd(m_e.v)));
                chk("seg", 32'(bus.o_Seg), 32'(model_seg(m_e.v)));
                chk("ovf", 32'(bus.o_Overflow), 32'(m_e.o));
                chk("latency", 32'(cyc - m_e.acc), 32'd9);
            end
            inflight = 0;
        end
        chk("ready", 32'(bus.o_Ready), 32'(!inflight));
        if (bus.i_Valid && bus.o_Ready) begin
            sb.push_back('{v: int'(bus.i_Bin), o: bus.i_Overflow, acc: cyc + 1});
            inflight = 1;
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!bus.o_Ready && t < 40) begin @(negedge clk); t++; end
        chk("accept_wait", 32'(bus.o_Ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic o);
        @(posedge clk); #1;
        bus.i_Valid = 1'b1; bus.i_Bin = b; bus.i_Overflow = o;
        wait_ready();
        @(posedge clk); #1;
        bus.i_Valid = 1'b0; bus.i_Bin = 8'($urandom); bus.i_Overflow = 1'($urandom);
    endtask

    task automatic disturb(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            bus.i_Valid = 1'($urandom); bus.i_Bin = 8'($urandom); bus.i_Overflow = 1'($urandom);
        end
        bus.i_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !bus.o_Ready) && t < 60) begin @(negedge clk); t++; end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset();
        chk("rst_ready", 32'(bus.o_Ready), 32'd1);
        chk("rst_done", 32'(bus.o_Done), 32'd0);
        chk("rst_ovf", 32'(bus.o_Overflow), 32'd0);
        chk("rst_bcd", 32'(bus.o_Bcd), 32'd0);
        chk("rst_seg", 32'(bus.o_Seg), 32'({BLK, BLK, 7'h40}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vals[3];
        int a[3];
        bus.i_Valid = 1'b0; bus.i_Bin = '0; bus.i_Overflow = 1'b0;
        repeat (3) @(posedge clk);
        #2; chk_reset();
        @(negedge clk); rst_n = 1'b1;

        send(8'd0, 1'b0);   wait_idle();
        send(8'd225, 1'b1); wait_idle();
        send(8'd255, 1'b0); wait_idle();
        send(8'd7, 1'b0);   wait_idle();

        vals = '{10, 99, 100};
        @(posedge clk); #1;
        bus.i_Valid = 1'b1; bus.i_Overflow = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.i_Bin = 8'(vals[j]);
            wait_ready();
            a[j] = cyc + 1;
            @(posedge clk); #1;
        end
        bus.i_Valid = 1'b0;
        chk("spacing1", 32'(a[1] - a[0]), 32'd10);
        chk("spacing2", 32'(a[2] - a[1]), 32'd10);
        wait_idle();

        send(8'd123, 1'b1); disturb(7); wait_idle();

        send(8'd200, 1'b0);
        repeat (4) @(posedge clk);
        #3; rst_n = 1'b0;
        sb.delete(); inflight = 0;
        #1; chk_reset();
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        send(8'd42, 1'b0); wait_idle();

        for (int k = 0; k < 30; k++) begin
            send(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) disturb(int'($urandom_range(1, 7)));
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
